// File: rtl/cpu_stat_display.sv
// cpu_stat_display: selects one of five CPU values with a debounced push-button
// and scans it onto an 8-digit multiplexed, active-low 7-segment display.
// A Freeze input holds the shown value and lights the leftmost decimal point.
module cpu_stat_display #(
    parameter int REFRESH_DIV     = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [31:0] Hex,
    input  logic [31:0] J,
    input  logic [31:0] R,
    input  logic [31:0] I,
    input  logic [31:0] TotalCycles,
    input  logic        BtnNext,
    input  logic        Freeze,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [2:0]  SelLed
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int RF_W = $clog2(REFRESH_DIV);

    typedef enum logic [2:0] {
        SRC_HEX = 3'd0,
        SRC_J   = 3'd1,
        SRC_R   = 3'd2,
        SRC_I   = 3'd3,
        SRC_CYC = 3'd4
    } sel_t;

    logic            sync_p0;
    logic            sync_p1;
    logic            stable;
    logic [DB_W-1:0] db_cnt;
    logic            press;
    sel_t            sel_q;
    sel_t            sel_d;
    logic [31:0]     src_val;
    logic [31:0]     disp_p0;
    logic [RF_W-1:0] ref_cnt;
    logic [2:0]      idx;
    logic [3:0]      nib;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Accepted press: synced level has been high and different from the
    // debounced level for the full debounce window. Releases never pulse.
    assign press = sync_p1 && !stable && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

    // Two-flop synchronizer for the raw asynchronous button
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= BtnNext;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: accept a new level only after it has held for the whole window
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            db_cnt <= '0;
            stable <= 1'b0;
        end else if (sync_p1 != stable) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_p1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Source-select state register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sel_q <= SRC_HEX;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Source-select next state: one step per press, wrapping after TotalCycles
    always_comb begin
        sel_d = sel_q;
        if (press) begin
            case (sel_q)
                SRC_HEX: sel_d = SRC_J;
                SRC_J:   sel_d = SRC_R;
                SRC_R:   sel_d = SRC_I;
                SRC_I:   sel_d = SRC_CYC;
                default: sel_d = SRC_HEX;
            endcase
        end
    end

    assign SelLed = sel_q;

    // Source multiplexer feeding the snapshot register
    always_comb begin
        src_val = Hex;
        case (sel_q)
            SRC_J:   src_val = J;
            SRC_R:   src_val = R;
            SRC_I:   src_val = I;
            SRC_CYC: src_val = TotalCycles;
            default: src_val = Hex;
        endcase
    end

    // Snapshot: follow the selected source unless frozen
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            disp_p0 <= '0;
        end else if (!Freeze) begin
            disp_p0 <= src_val;
        end
    end

    // Scan timing: dwell REFRESH_DIV cycles on each digit, then move to the next
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ref_cnt <= '0;
            idx     <= 3'd0;
        end else if (ref_cnt == RF_W'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= idx + 3'd1;
        end else begin
            ref_cnt <= ref_cnt + RF_W'(1);
        end
    end

    assign nib = disp_p0[{idx, 2'b00} +: 4];

    // Registered pin drivers; DP on the leftmost digit flags a frozen display
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            AN  <= 8'hFF;
            SEG <= 7'h7F;
            DP  <= 1'b1;
        end else begin
            AN  <= ~(8'b1 << idx);
            SEG <= hex_decode(nib);
            DP  <= ~(Freeze && (idx == 3'd7));
        end
    end

endmodule

// File: tb/tb_cpu_stat_display.sv
// Self-checking bench for cpu_stat_display with a short refresh and debounce.
module tb_cpu_stat_display;

    localparam int RDIV = 2;
    localparam int DBC  = 4;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [31:0] Hex = '0;
    logic [31:0] J = '0;
    logic [31:0] R = '0;
    logic [31:0] I = '0;
    logic [31:0] TotalCycles = '0;
    logic        BtnNext = 1'b0;
    logic        Freeze = 1'b0;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic [2:0]  SelLed;

    int n_checks = 0;
    int n_fail   = 0;
    int sel_model = 0;

    logic [6:0] seg_seen [8];
    logic       dp_seen  [8];
    logic [7:0] seen;
    int         bad_an;

    cpu_stat_display #(
        .REFRESH_DIV    (RDIV),
        .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Hex        (Hex),
        .J          (J),
        .R          (R),
        .I          (I),
        .TotalCycles(TotalCycles),
        .BtnNext    (BtnNext),
        .Freeze     (Freeze),
        .AN         (AN),
        .SEG        (SEG),
        .DP         (DP),
        .SelLed     (SelLed)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [6:0] exp_seg(input logic [31:0] v, input int k);
        logic [3:0] n;
        n = v[4*k +: 4];
        return SEG_TBL[n];
    endfunction

    function automatic logic [31:0] model_src(input int s);
        case (s)
            1: return J;
            2: return R;
            3: return I;
            4: return TotalCycles;
            default: return Hex;
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge Clock);
        Resetn  = 1'b0;
        BtnNext = 1'b0;
        repeat (2) @(negedge Clock);
        Resetn    = 1'b1;
        sel_model = 0;
    endtask

    // Records which segment pattern and DP accompany each enabled digit.
    task automatic scan_capture(input int ncyc);
        seen   = '0;
        bad_an = 0;
        for (int c = 0; c < ncyc; c++) begin
            int k;
            @(negedge Clock);
            k = -1;
            for (int d = 0; d < 8; d++) if (AN == ~(8'b1 << d)) k = d;
            if (k < 0) bad_an++;
            else begin
                seg_seen[k] = SEG;
                dp_seen[k]  = DP;
                seen[k]     = 1'b1;
            end
        end
    endtask

    task automatic press_btn(input int hi);
        @(negedge Clock);
        BtnNext = 1'b1;
        repeat (hi) @(negedge Clock);
        BtnNext = 1'b0;
        repeat (10) @(negedge Clock);
        if (hi >= DBC) sel_model = (sel_model + 1) % 5;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        Hex    = 32'h12345678;
        repeat (3) @(negedge Clock);
        n_checks++; if (AN !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h, required ff", AN); end
        n_checks++; if (SEG !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h, required 7f", SEG); end
        n_checks++; if (DP !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b, required 1", DP); end
        n_checks++; if (SelLed !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d, required 0", SelLed); end
        Resetn = 1'b1;
        sel_model = 0;
        for (int n = 1; n <= 16; n++) begin
            int k;
            logic [6:0] es;
            @(negedge Clock);
            k  = ((n - 1) / RDIV) % 8;
            es = (n == 1) ? 7'h40 : exp_seg(Hex, k);
            n_checks++;
            if (AN !== ~(8'b1 << k)) begin
                n_fail++; $display("FAIL scan_an cycle %0d: got %h, required %h", n, AN, ~(8'b1 << k));
            end
            n_checks++;
            if (SEG !== es) begin
                n_fail++; $display("FAIL scan_seg cycle %0d: got %h, required %h", n, SEG, es);
            end
        end
    endtask

    task automatic test_debounce();
        apply_reset();
        J = 32'h0000000A;
        press_btn(3);
        n_checks++; if (SelLed !== 3'd0) begin n_fail++; $display("FAIL short_press: got %0d, required 0", SelLed); end
        press_btn(8);
        n_checks++; if (SelLed !== 3'd1) begin n_fail++; $display("FAIL long_press: got %0d, required 1", SelLed); end
        scan_capture(20);
        n_checks++; if (bad_an != 0 || seen !== 8'hFF) begin n_fail++; $display("FAIL j_scan_an: got bad=%0d seen=%h, required bad=0 seen=ff", bad_an, seen); end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (seg_seen[k] !== ((k == 0) ? 7'h08 : 7'h40)) begin
                n_fail++; $display("FAIL j_digit%0d: got %h, required %h", k, seg_seen[k], (k == 0) ? 7'h08 : 7'h40);
            end
        end
        // Random bounce bursts followed by a press of random length
        for (int t = 0; t < 6; t++) begin
            int ng;
            Hex = $urandom; J = $urandom; R = $urandom; I = $urandom; TotalCycles = $urandom;
            ng = $urandom_range(0, 3);
            for (int g = 0; g < ng; g++) begin
                @(negedge Clock);
                BtnNext = 1'b1;
                repeat ($urandom_range(1, DBC - 1)) @(negedge Clock);
                BtnNext = 1'b0;
                repeat ($urandom_range(2, 4)) @(negedge Clock);
            end
            press_btn($urandom_range(1, 8));
            n_checks++;
            if (SelLed !== 3'(sel_model)) begin
                n_fail++; $display("FAIL rand_press%0d: got %0d, required %0d", t, SelLed, sel_model);
            end
            scan_capture(20);
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (seg_seen[k] !== exp_seg(model_src(sel_model), k)) begin
                    n_fail++; $display("FAIL rand_digit%0d t%0d: got %h, required %h", k, t, seg_seen[k], exp_seg(model_src(sel_model), k));
                end
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        Hex = $urandom; J = $urandom; R = $urandom; I = $urandom; TotalCycles = $urandom;
        for (int p = 1; p <= 6; p++) begin
            if (p <= 5) press_btn(DBC + 2);
            else repeat (3) @(negedge Clock);
            n_checks++;
            if (SelLed !== 3'(sel_model)) begin
                n_fail++; $display("FAIL wrap_sel step%0d: got %0d, required %0d", p, SelLed, sel_model);
            end
            scan_capture(20);
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (seg_seen[k] !== exp_seg(model_src(sel_model), k)) begin
                    n_fail++; $display("FAIL wrap_digit%0d step%0d: got %h, required %h", k, p, seg_seen[k], exp_seg(model_src(sel_model), k));
                end
            end
        end
    endtask

    task automatic test_freeze();
        logic [31:0] held;
        apply_reset();
        Hex = 32'hCAFE0001;
        repeat (3) @(negedge Clock);
        Freeze = 1'b1;
        Hex    = 32'h0;
        repeat (2) @(negedge Clock);
        scan_capture(20);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (seg_seen[k] !== exp_seg(32'hCAFE0001, k) || dp_seen[k] !== (k != 7)) begin
                n_fail++; $display("FAIL frozen_digit%0d: got seg=%h dp=%b, required seg=%h dp=%b", k, seg_seen[k], dp_seen[k], exp_seg(32'hCAFE0001, k), k != 7);
            end
        end
        @(negedge Clock);
        Freeze = 1'b0;
        repeat (8 * RDIV + 2) @(negedge Clock);
        scan_capture(20);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (seg_seen[k] !== 7'h40 || dp_seen[k] !== 1'b1) begin
                n_fail++; $display("FAIL unfrozen_digit%0d: got seg=%h dp=%b, required seg=40 dp=1", k, seg_seen[k], dp_seen[k]);
            end
        end
        // Press accepted on the same edge that Freeze rises
        Hex  = $urandom;
        held = Hex;
        J    = $urandom;
        repeat (3) @(negedge Clock);
        BtnNext = 1'b1;
        repeat (DBC + 1) @(posedge Clock);
        @(negedge Clock);
        Freeze = 1'b1;
        Hex    = $urandom;
        repeat (3) @(negedge Clock);
        BtnNext = 1'b0;
        repeat (10) @(negedge Clock);
        sel_model = 1;
        n_checks++;
        if (SelLed !== 3'd1) begin n_fail++; $display("FAIL freeze_press_sel: got %0d, required 1", SelLed); end
        scan_capture(20);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (seg_seen[k] !== exp_seg(held, k)) begin
                n_fail++; $display("FAIL freeze_press_digit%0d: got %h, required %h", k, seg_seen[k], exp_seg(held, k));
            end
        end
        @(negedge Clock);
        Freeze = 1'b0;
        repeat (3) @(negedge Clock);
        scan_capture(20);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (seg_seen[k] !== exp_seg(J, k)) begin
                n_fail++; $display("FAIL after_freeze_digit%0d: got %h, required %h", k, seg_seen[k], exp_seg(J, k));
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        Hex = 32'h89ABCDEF;
        repeat (7) @(posedge Clock);
        @(negedge Clock);
        BtnNext = 1'b1;
        repeat (4) @(posedge Clock);
        #1;
        n_checks++;
        if (AN !== 8'hDF) begin n_fail++; $display("FAIL pre_reset_an: got %h, required df", AN); end
        #1;
        Resetn  = 1'b0;
        BtnNext = 1'b0;
        #1;
        n_checks++;
        if (AN !== 8'hFF || SEG !== 7'h7F || DP !== 1'b1) begin
            n_fail++; $display("FAIL async_reset_out: got an=%h seg=%h dp=%b, required an=ff seg=7f dp=1", AN, SEG, DP);
        end
        @(negedge Clock);
        Resetn    = 1'b1;
        sel_model = 0;
        @(negedge Clock);
        n_checks++;
        if (AN !== 8'hFE || SEG !== 7'h40) begin
            n_fail++; $display("FAIL first_edge: got an=%h seg=%h, required an=fe seg=40", AN, SEG);
        end
        repeat (12) @(negedge Clock);
        n_checks++;
        if (SelLed !== 3'd0) begin n_fail++; $display("FAIL no_pending_press: got %0d, required 0", SelLed); end
    endtask

    task automatic test_decode();
        logic [31:0] vals [5];
        apply_reset();
        vals[0] = 32'h76543210;
        vals[1] = 32'hFEDCBA98;
        vals[2] = $urandom;
        vals[3] = $urandom;
        vals[4] = $urandom;
        for (int v = 0; v < 5; v++) begin
            Hex = vals[v];
            repeat (3) @(negedge Clock);
            scan_capture(20);
            n_checks++;
            if (bad_an != 0 || seen !== 8'hFF) begin
                n_fail++; $display("FAIL decode_an v%0d: got bad=%0d seen=%h, required bad=0 seen=ff", v, bad_an, seen);
            end
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (seg_seen[k] !== exp_seg(vals[v], k)) begin
                    n_fail++; $display("FAIL decode v%0d digit%0d: got %h, required %h", v, k, seg_seen[k], exp_seg(vals[v], k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_freeze();
        test_async_reset();
        test_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
